// File: rtl/demux_pkg.sv
// demux_pkg: shared state encoding and limits for stream_demux_1xn
package demux_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, FWD = 2'd1, DROP = 2'd2} state_t;
    localparam int MAX_OUT = 16;
endpackage

// File: rtl/pipe_reg.sv
// pipe_reg: one-entry valid/ready register that reloads in the same cycle it drains
module pipe_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk)
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
endmodule

// File: rtl/stream_demux_1xn.sv
// stream_demux_1xn: registered 1-to-N stream demux with per-packet destination lock
module stream_demux_1xn
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = $clog2(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    input  logic                   in_last,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [N_OUT-1:0]       out_last,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic                   err_sel
);
    localparam int RW = WIDTH + 1 + SEL_W;

    state_t           state;
    logic             full_q, last_q, legal, accept, load, reg_ready;
    logic [WIDTH-1:0] data_q;
    logic [SEL_W-1:0] dest_q;

    assign legal    = 32'(in_sel) < N_OUT;
    // Dropped beats never touch the register, so they bypass its backpressure
    assign in_ready = state == DROP || (state == IDLE && !legal) || reg_ready;
    assign accept   = in_valid && in_ready;
    assign load     = accept && (state == FWD || (state == IDLE && legal));

    pipe_reg #(.W(RW)) u_reg (
        .clk       (clk),
        .rst       (rst),
        .in_data   ({in_data, in_last, state == FWD ? dest_q : in_sel}),
        .in_valid  (load),
        .in_ready  (reg_ready),
        .out_data  ({data_q, last_q, dest_q}),
        .out_valid (full_q),
        .out_ready (out_ready[dest_q])
    );

    always_ff @(posedge clk)
        if (rst) begin
            state   <= IDLE;
            err_sel <= 1'b0;
        end else begin
            err_sel <= accept && state == IDLE && !legal;
            if (accept)
                state <= in_last ? IDLE : state == IDLE ? (legal ? FWD : DROP) : state;
        end

    for (genvar i = 0; i < N_OUT; i++) begin : g_lane
        assign out_valid[i]                = full_q && dest_q == SEL_W'(i);
        assign out_data[i*WIDTH +: WIDTH]  = out_valid[i] ? data_q : '0;
        assign out_last[i]                 = out_valid[i] && last_q;
    end
endmodule

// File: tb/tb_stream_demux_1xn.sv
// tb_stream_demux_1xn: vector table on a 4-lane instance, model-checked directed and random traffic on a 3-lane instance
module tb_stream_demux_1xn;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, in_valid = 1'b0, in_last = 1'b0;
    logic [1:0] in_sel = '0;
    logic [7:0] in_data = '0;

    logic [3:0]  a_ordy = 4'hF, a_ov, a_ol;
    logic [31:0] a_od;
    logic        a_irdy, a_err;

    logic [2:0]  b_ordy = 3'b111, b_ov, b_ol;
    logic [23:0] b_od;
    logic        b_irdy, b_err;

    stream_demux_1xn #(.WIDTH(8), .N_OUT(4)) dut_a (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
        .in_valid(in_valid), .in_ready(a_irdy), .out_data(a_od), .out_last(a_ol),
        .out_valid(a_ov), .out_ready(a_ordy), .err_sel(a_err)
    );

    stream_demux_1xn #(.WIDTH(8), .N_OUT(3)) dut_b (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_last(in_last),
        .in_valid(in_valid), .in_ready(b_irdy), .out_data(b_od), .out_last(b_ol),
        .out_valid(b_ov), .out_ready(b_ordy), .err_sel(b_err)
    );

    int checks = 0, errors = 0;

    typedef struct {
        logic        r, v;
        logic [1:0]  s;
        logic [7:0]  d;
        logic        l;
        logic [3:0]  o;
        logic        chk, ir;
        logic [3:0]  ov;
        logic [31:0] od;
        logic [3:0]  ol;
        logic        e;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic r, logic v, logic [1:0] s, logic [7:0] d, logic l, logic [3:0] o,
                                logic chk, logic ir, logic [3:0] ov, logic [31:0] od, logic [3:0] ol, logic e);
        vec_t t;
        t.r = r; t.v = v; t.s = s; t.d = d; t.l = l; t.o = o;
        t.chk = chk; t.ir = ir; t.ov = ov; t.od = od; t.ol = ol; t.e = e;
        return t;
    endfunction

    // Reference model for the 3-lane instance: a queue of at most one held beat,
    // plus the current packet's destination (-1 while discarding a packet).
    int         q_dest[$];
    logic [7:0] q_data[$];
    logic       q_last[$];
    bit         in_pkt = 0, m_err = 0, mvalid = 0;
    int         pkt_dest = 0;
    int         err_seen = 0, ov_seen = 0;

    task automatic b_cycle(input logic r, input logic v, input logic [1:0] s, input logic [7:0] d,
                           input logic l, input logic [2:0] o);
        logic [2:0]  eov, eol;
        logic [23:0] eod;
        logic        eir, acc, drn;
        int          tgt;
        rst = r; in_valid = v; in_sel = s; in_data = d; in_last = l; b_ordy = o;
        #1;
        eov = '0; eol = '0; eod = '0;
        if (q_dest.size() > 0) begin
            eov[q_dest[0]] = 1'b1;
            eol[q_dest[0]] = q_last[0];
            eod[q_dest[0]*8 +: 8] = q_data[0];
        end
        eir = (in_pkt && pkt_dest < 0) || (!in_pkt && s >= 2'd3) || q_dest.size() == 0 || o[q_dest[0]];
        err_seen += int'(b_err);
        ov_seen  += int'(|b_ov);
        if (mvalid) begin
            checks++;
            if ({b_irdy, b_ov, b_od, b_ol, b_err} !== {eir, eov, eod, eol, m_err}) begin
                errors++;
                $display("FAIL b_cycle t=%0t got irdy=%b ov=%b od=%h ol=%b err=%b want irdy=%b ov=%b od=%h ol=%b err=%b",
                         $time, b_irdy, b_ov, b_od, b_ol, b_err, eir, eov, eod, eol, m_err);
            end
        end
        @(posedge clk);
        #1;
        if (r) begin
            q_dest.delete(); q_data.delete(); q_last.delete();
            in_pkt = 0; m_err = 0; mvalid = 1;
        end else begin
            acc = v && eir;
            drn = q_dest.size() > 0 && o[q_dest[0]];
            if (drn) begin
                void'(q_dest.pop_front()); void'(q_data.pop_front()); void'(q_last.pop_front());
            end
            tgt = in_pkt ? pkt_dest : (s < 2'd3 ? int'(s) : -1);
            m_err = acc && !in_pkt && tgt < 0;
            if (acc) begin
                if (tgt >= 0) begin
                    q_dest.push_back(tgt); q_data.push_back(d); q_last.push_back(l);
                end
                in_pkt = !l;
                pkt_dest = tgt;
            end
        end
    endtask

    initial begin
        tv.push_back(mk(1,0,0,8'h00,0,4'hF, 0, 0,4'b0000,32'h0,4'b0000,0));
        tv.push_back(mk(1,1,2,8'h5A,1,4'hF, 1, 1,4'b0000,32'h0,4'b0000,0));
        tv.push_back(mk(0,0,0,8'h00,0,4'hF, 1, 1,4'b0000,32'h0,4'b0000,0));
        tv.push_back(mk(0,1,2,8'hA5,1,4'hF, 1, 1,4'b0000,32'h0,4'b0000,0));
        tv.push_back(mk(0,0,0,8'h00,0,4'hF, 1, 1,4'b0100,32'h00A50000,4'b0100,0));
        tv.push_back(mk(0,0,0,8'h00,0,4'hF, 1, 1,4'b0000,32'h0,4'b0000,0));
        tv.push_back(mk(0,1,1,8'h11,0,4'hF, 1, 1,4'b0000,32'h0,4'b0000,0));
        tv.push_back(mk(0,1,3,8'h22,0,4'hF, 1, 1,4'b0010,32'h00001100,4'b0000,0));
        tv.push_back(mk(0,1,0,8'h33,1,4'hF, 1, 1,4'b0010,32'h00002200,4'b0000,0));
        tv.push_back(mk(0,0,0,8'h00,0,4'hF, 1, 1,4'b0010,32'h00003300,4'b0010,0));
        tv.push_back(mk(0,0,0,8'h00,0,4'hF, 1, 1,4'b0000,32'h0,4'b0000,0));
        tv.push_back(mk(0,1,1,8'h44,0,4'hF, 1, 1,4'b0000,32'h0,4'b0000,0));
        tv.push_back(mk(0,1,1,8'h55,1,4'b1101, 1, 0,4'b0010,32'h00004400,4'b0000,0));
        tv.push_back(mk(0,1,1,8'h55,1,4'b1101, 1, 0,4'b0010,32'h00004400,4'b0000,0));
        tv.push_back(mk(0,1,1,8'h55,1,4'hF, 1, 1,4'b0010,32'h00004400,4'b0000,0));
        tv.push_back(mk(0,0,0,8'h00,0,4'hF, 1, 1,4'b0010,32'h00005500,4'b0010,0));
        tv.push_back(mk(0,0,0,8'h00,0,4'hF, 1, 1,4'b0000,32'h0,4'b0000,0));
        tv.push_back(mk(0,1,0,8'h66,1,4'hF, 1, 1,4'b0000,32'h0,4'b0000,0));
        tv.push_back(mk(0,1,3,8'h77,1,4'b0110, 1, 0,4'b0001,32'h00000066,4'b0001,0));
        tv.push_back(mk(0,1,3,8'h77,1,4'hF, 1, 1,4'b0001,32'h00000066,4'b0001,0));
        tv.push_back(mk(0,0,0,8'h00,0,4'hF, 1, 1,4'b1000,32'h77000000,4'b1000,0));
        tv.push_back(mk(0,0,0,8'h00,0,4'hF, 1, 1,4'b0000,32'h0,4'b0000,0));
        tv.push_back(mk(0,1,2,8'h81,0,4'h0, 1, 1,4'b0000,32'h0,4'b0000,0));
        tv.push_back(mk(1,0,0,8'h00,0,4'h0, 1, 0,4'b0100,32'h00810000,4'b0000,0));
        tv.push_back(mk(0,1,1,8'h99,1,4'hF, 1, 1,4'b0000,32'h0,4'b0000,0));
        tv.push_back(mk(0,0,0,8'h00,0,4'hF, 1, 1,4'b0010,32'h00009900,4'b0010,0));
        tv.push_back(mk(0,0,0,8'h00,0,4'hF, 1, 1,4'b0000,32'h0,4'b0000,0));

        @(posedge clk);
        #1;
        foreach (tv[k]) begin
            rst = tv[k].r; in_valid = tv[k].v; in_sel = tv[k].s;
            in_data = tv[k].d; in_last = tv[k].l; a_ordy = tv[k].o;
            #1;
            if (tv[k].chk) begin
                checks++;
                if ({a_irdy, a_ov, a_od, a_ol, a_err} !== {tv[k].ir, tv[k].ov, tv[k].od, tv[k].ol, tv[k].e}) begin
                    errors++;
                    $display("FAIL vec%0d got irdy=%b ov=%b od=%h ol=%b err=%b want irdy=%b ov=%b od=%h ol=%b err=%b",
                             k, a_irdy, a_ov, a_od, a_ol, a_err, tv[k].ir, tv[k].ov, tv[k].od, tv[k].ol, tv[k].e);
                end
            end
            @(posedge clk);
            #1;
        end

        b_cycle(1, 0, 0, 8'h00, 0, 3'b111);
        b_cycle(1, 0, 0, 8'h00, 0, 3'b111);
        err_seen = 0; ov_seen = 0;
        b_cycle(0, 1, 3, 8'hAA, 0, 3'b111);
        b_cycle(0, 1, 3, 8'hBB, 1, 3'b111);
        b_cycle(0, 0, 0, 8'h00, 0, 3'b111);
        b_cycle(0, 0, 0, 8'h00, 0, 3'b111);
        checks++;
        if (err_seen != 1) begin
            errors++;
            $display("FAIL err_pulse_count got %0d want 1", err_seen);
        end
        checks++;
        if (ov_seen != 0) begin
            errors++;
            $display("FAIL drop_no_valid got %0d valid cycles want 0", ov_seen);
        end
        b_cycle(0, 1, 0, 8'hCC, 1, 3'b111);
        b_cycle(0, 0, 0, 8'h00, 0, 3'b111);
        b_cycle(0, 0, 0, 8'h00, 0, 3'b111);
        b_cycle(0, 1, 2, 8'hDD, 1, 3'b011);
        b_cycle(0, 1, 3, 8'hEE, 1, 3'b011);
        b_cycle(0, 0, 0, 8'h00, 0, 3'b111);
        b_cycle(0, 0, 0, 8'h00, 0, 3'b111);

        for (int n = 0; n < 600; n++) begin
            logic [2:0] o;
            o[0] = $urandom_range(3) != 0;
            o[1] = $urandom_range(3) != 0;
            o[2] = $urandom_range(3) != 0;
            b_cycle($urandom_range(39) == 0, $urandom_range(3) != 0, 2'($urandom_range(3)),
                    8'($urandom), $urandom_range(2) == 0, o);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
